// File: rtl/id_decode_pkg.sv
// Shared constants for the instruction decode stage: ALU select codes, RV32I opcodes,
// write-back source encodings and the stage FSM state type.
package id_decode_pkg;

    localparam int ALU_ADD    = 0;
    localparam int ALU_SUB    = 1;
    localparam int ALU_SLT    = 2;
    localparam int ALU_SLTU   = 3;
    localparam int ALU_XOR    = 4;
    localparam int ALU_OR     = 5;
    localparam int ALU_AND    = 6;
    localparam int ALU_SLL    = 7;
    localparam int ALU_SRL    = 8;
    localparam int ALU_SRA    = 9;
    localparam int ALU_LUI    = 10;
    localparam int ALU_M_BASE = 16;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] WB_LOAD = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

endpackage

// File: rtl/id_decode_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle. The slave modport is the
// decode unit; the master modport is the surrounding pipeline (fetch + execute).
interface id_decode_if #(
    parameter int XLEN      = 32,
    parameter int ALU_SEL_W = 5
);
    logic [XLEN-1:0]      i_inst_id;
    logic                 i_valid_id;
    logic                 o_ready_id;
    logic                 i_flush;

    logic                 o_valid_ex;
    logic                 i_ready_ex;
    logic [XLEN-1:0]      o_inst_ex;
    logic [4:0]           o_imm_sel_ex;
    logic [ALU_SEL_W-1:0] o_alu_sel_ex;
    logic                 o_reg_wren_ex;
    logic                 o_mem_wren_ex;
    logic                 o_a_sel_ex;
    logic                 o_b_sel_ex;
    logic                 o_brun_ex;
    logic [1:0]           o_wb_sel_ex;
    logic [2:0]           o_funct3_ex;
    logic                 o_illegal_ex;
    logic [15:0]          o_stall_cnt;

    modport master (
        output i_inst_id, i_valid_id, i_flush, i_ready_ex,
        input  o_ready_id, o_valid_ex, o_inst_ex, o_imm_sel_ex, o_alu_sel_ex,
               o_reg_wren_ex, o_mem_wren_ex, o_a_sel_ex, o_b_sel_ex, o_brun_ex,
               o_wb_sel_ex, o_funct3_ex, o_illegal_ex, o_stall_cnt
    );

    modport slave (
        input  i_inst_id, i_valid_id, i_flush, i_ready_ex,
        output o_ready_id, o_valid_ex, o_inst_ex, o_imm_sel_ex, o_alu_sel_ex,
               o_reg_wren_ex, o_mem_wren_ex, o_a_sel_ex, o_b_sel_ex, o_brun_ex,
               o_wb_sel_ex, o_funct3_ex, o_illegal_ex, o_stall_cnt
    );
endinterface

// File: rtl/id_decode_comb.sv
// Combinational RV32I decoder producing datapath controls and register-use info.
// Define ID_DECODE_RV32M_EN to decode the M extension (funct7 0000001) instead of trapping it.
module id_decode_comb #(
    parameter int XLEN      = 32,
    parameter int ALU_SEL_W = 5
) (
    input  logic [XLEN-1:0]      inst,
    output logic [4:0]           imm_sel,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 reg_wren,
    output logic                 mem_wren,
    output logic                 a_sel,
    output logic                 b_sel,
    output logic                 brun,
    output logic [1:0]           wb_sel,
    output logic [2:0]           funct3,
    output logic                 illegal,
    output logic                 is_load,
    output logic                 use_rs1,
    output logic                 use_rs2,
    output logic [4:0]           rd,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2
);
    import id_decode_pkg::*;

    logic [6:0]           opcode;
    logic [6:0]           funct7;
    logic [ALU_SEL_W-1:0] base_alu;
    logic [ALU_SEL_W-1:0] alu_raw;
    logic                 wren_raw;
    logic                 mem_raw;

    function automatic logic [ALU_SEL_W-1:0] sel(input int code);
        return ALU_SEL_W'(code);
    endfunction

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    // SUB exists only for register-register ops; SRA/SRAI share the funct7 alternate
    always_comb begin
        base_alu = sel(ALU_ADD);
        case (funct3)
            3'b000:  base_alu = (opcode == OP_REG && funct7 == F7_ALT) ? sel(ALU_SUB) : sel(ALU_ADD);
            3'b001:  base_alu = sel(ALU_SLL);
            3'b010:  base_alu = sel(ALU_SLT);
            3'b011:  base_alu = sel(ALU_SLTU);
            3'b100:  base_alu = sel(ALU_XOR);
            3'b101:  base_alu = (funct7 == F7_ALT) ? sel(ALU_SRA) : sel(ALU_SRL);
            3'b110:  base_alu = sel(ALU_OR);
            default: base_alu = sel(ALU_AND);
        endcase
    end

    always_comb begin
        imm_sel  = 5'b00000;
        alu_raw  = sel(ALU_ADD);
        wren_raw = 1'b0;
        mem_raw  = 1'b0;
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        brun     = 1'b0;
        wb_sel   = WB_ALU;
        illegal  = 1'b0;
        is_load  = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (opcode)
            OP_LUI: begin
                imm_sel = 5'b01000; alu_raw = sel(ALU_LUI); b_sel = 1'b1; wren_raw = 1'b1;
            end
            OP_AUIPC: begin
                imm_sel = 5'b01000; a_sel = 1'b1; b_sel = 1'b1; wren_raw = 1'b1;
            end
            OP_JAL: begin
                imm_sel = 5'b10000; a_sel = 1'b1; b_sel = 1'b1; wren_raw = 1'b1; wb_sel = WB_PC4;
            end
            OP_JALR: begin
                imm_sel = 5'b00001; b_sel = 1'b1; wren_raw = 1'b1; wb_sel = WB_PC4; use_rs1 = 1'b1;
            end
            OP_BRANCH: begin
                imm_sel = 5'b00100; a_sel = 1'b1; b_sel = 1'b1;
                brun    = funct3[2] & funct3[1];
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_LOAD: begin
                imm_sel = 5'b00001; b_sel = 1'b1; wren_raw = 1'b1; wb_sel = WB_LOAD;
                is_load = 1'b1; use_rs1 = 1'b1;
            end
            OP_STORE: begin
                imm_sel = 5'b00010; b_sel = 1'b1; mem_raw = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_IMM: begin
                imm_sel = 5'b00001; b_sel = 1'b1; wren_raw = 1'b1; use_rs1 = 1'b1;
                alu_raw = base_alu;
                if (funct3 == 3'b001 && funct7 != F7_BASE)
                    illegal = 1'b1;
                if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)
                    illegal = 1'b1;
            end
            OP_REG: begin
                wren_raw = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                alu_raw  = base_alu;
                if (funct7 == F7_MULDIV) begin
`ifdef ID_DECODE_RV32M_EN
                    alu_raw = sel(ALU_M_BASE + int'(funct3));
`else
                    illegal = 1'b1;
`endif
                end else if (!(funct7 == F7_BASE ||
                               (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
                    illegal = 1'b1;
                end
            end
            OP_FENCE, OP_SYSTEM: begin
                // architecturally legal but no datapath effect in this pipeline
            end
            default: illegal = 1'b1;
        endcase
    end

    assign alu_sel  = illegal ? sel(ALU_ADD) : alu_raw;
    assign reg_wren = wren_raw & ~illegal;
    assign mem_wren = mem_raw & ~illegal;

endmodule

// File: rtl/id_decode_unit.sv
// Decode stage: registers the decoded bundle, handles the execute handshake, inserts
// one bubble on load-use and counts those bubbles (saturating).
//   state     | meaning
//   ST_EMPTY  | no bundle held, ready for fetch
//   ST_FULL   | valid bundle presented to execute
//   ST_BUBBLE | load consumed, dependent instruction delayed one cycle
module id_decode_unit #(
    parameter int XLEN      = 32,
    parameter int ALU_SEL_W = 5
) (
    input logic        i_clk,
    input logic        i_rst_n,
    id_decode_if.slave bus
);
    import id_decode_pkg::*;

    state_t state, state_nxt;

    logic [4:0]           dec_imm_sel;
    logic [ALU_SEL_W-1:0] dec_alu_sel;
    logic                 dec_reg_wren, dec_mem_wren, dec_a_sel, dec_b_sel, dec_brun;
    logic [1:0]           dec_wb_sel;
    logic [2:0]           dec_funct3;
    logic                 dec_illegal, dec_is_load, dec_use_rs1, dec_use_rs2;
    logic [4:0]           dec_rd, dec_rs1, dec_rs2;

    logic [XLEN-1:0]      inst_q;
    logic [4:0]           imm_sel_q;
    logic [ALU_SEL_W-1:0] alu_sel_q;
    logic                 reg_wren_q, mem_wren_q, a_sel_q, b_sel_q, brun_q;
    logic [1:0]           wb_sel_q;
    logic [2:0]           funct3_q;
    logic                 illegal_q;
    logic                 held_is_load;
    logic [4:0]           held_rd;
    logic [15:0]          stall_cnt;

    logic valid_ex, load_use, ready_id, accept, stall_inc;

    id_decode_comb #(.XLEN(XLEN), .ALU_SEL_W(ALU_SEL_W)) u_comb (
        .inst     (bus.i_inst_id),
        .imm_sel  (dec_imm_sel),
        .alu_sel  (dec_alu_sel),
        .reg_wren (dec_reg_wren),
        .mem_wren (dec_mem_wren),
        .a_sel    (dec_a_sel),
        .b_sel    (dec_b_sel),
        .brun     (dec_brun),
        .wb_sel   (dec_wb_sel),
        .funct3   (dec_funct3),
        .illegal  (dec_illegal),
        .is_load  (dec_is_load),
        .use_rs1  (dec_use_rs1),
        .use_rs2  (dec_use_rs2),
        .rd       (dec_rd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2)
    );

    assign valid_ex = (state == ST_FULL);
    assign load_use = valid_ex && held_is_load && (held_rd != 5'd0) && bus.i_valid_id &&
                      ((dec_use_rs1 && dec_rs1 == held_rd) || (dec_use_rs2 && dec_rs2 == held_rd));
    assign ready_id = bus.i_flush || (!load_use && (!valid_ex || bus.i_ready_ex));
    assign accept   = bus.i_valid_id && ready_id && !bus.i_flush;

    always_comb begin
        state_nxt = state;
        stall_inc = 1'b0;
        if (bus.i_flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY, ST_BUBBLE: state_nxt = accept ? ST_FULL : ST_EMPTY;
                ST_FULL: begin
                    if (load_use && bus.i_ready_ex) begin
                        state_nxt = ST_BUBBLE;
                        stall_inc = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_FULL;
                    end else if (bus.i_ready_ex) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_EMPTY;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inst_q       <= '0;
            imm_sel_q    <= '0;
            alu_sel_q    <= ALU_SEL_W'(ALU_ADD);
            reg_wren_q   <= 1'b0;
            mem_wren_q   <= 1'b0;
            a_sel_q      <= 1'b0;
            b_sel_q      <= 1'b0;
            brun_q       <= 1'b0;
            wb_sel_q     <= WB_ALU;
            funct3_q     <= '0;
            illegal_q    <= 1'b0;
            held_is_load <= 1'b0;
            held_rd      <= '0;
        end else if (accept) begin
            inst_q       <= bus.i_inst_id;
            imm_sel_q    <= dec_imm_sel;
            alu_sel_q    <= dec_alu_sel;
            reg_wren_q   <= dec_reg_wren;
            mem_wren_q   <= dec_mem_wren;
            a_sel_q      <= dec_a_sel;
            b_sel_q      <= dec_b_sel;
            brun_q       <= dec_brun;
            wb_sel_q     <= dec_wb_sel;
            funct3_q     <= dec_funct3;
            illegal_q    <= dec_illegal;
            held_is_load <= dec_is_load;
            held_rd      <= dec_rd;
        end
    end

    // flush has priority, so a load-use coinciding with flush is not counted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                stall_cnt <= '0;
        else if (stall_inc && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end

    assign bus.o_ready_id    = ready_id;
    assign bus.o_valid_ex    = valid_ex;
    assign bus.o_inst_ex     = inst_q;
    assign bus.o_imm_sel_ex  = imm_sel_q;
    assign bus.o_alu_sel_ex  = alu_sel_q;
    assign bus.o_reg_wren_ex = reg_wren_q;
    assign bus.o_mem_wren_ex = mem_wren_q;
    assign bus.o_a_sel_ex    = a_sel_q;
    assign bus.o_b_sel_ex    = b_sel_q;
    assign bus.o_brun_ex     = brun_q;
    assign bus.o_wb_sel_ex   = wb_sel_q;
    assign bus.o_funct3_ex   = funct3_q;
    assign bus.o_illegal_ex  = illegal_q;
    assign bus.o_stall_cnt   = stall_cnt;

endmodule
